// File: rtl/math_pipelined_arbiter.sv
// Round-robin front end that shares one chunked ripple add/sub unit among NUM_REQ requesters.
// Only one operation is in flight at a time; the result is held on a valid/ready response port.

// Chunked add/sub unit. A ce pulse loads b and computes chunk 0. Each following cycle computes
// the next chunk from the held a operand and the carry of the previous chunk.
module math_pipelined #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_i,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_sub
);
    localparam int CW = (WIDTH + LATENCY - 1) / LATENCY;
    localparam int PW = CW * LATENCY;
    localparam int IW = $clog2(LATENCY + 1);

    logic [PW-1:0] r_b;
    logic [PW-1:0] r_sum;
    logic [PW-1:0] r_sub;
    logic          r_cs;
    logic          r_cd;
    logic [IW-1:0] r_idx;

    logic [PW-1:0] w_a_pad;
    logic [PW-1:0] w_b_pad;
    logic [PW-1:0] w_mask;
    logic [31:0]   w_sh;
    logic [CW-1:0] w_ac;
    logic [CW-1:0] w_bc;
    logic [CW:0]   w_s;
    logic [CW:0]   w_d;
    logic          w_step;

    // Select the active chunk and form its sum and difference with the running carries.
    always_comb begin
        w_a_pad = PW'(i_d);
        w_b_pad = i_ce ? PW'(i_i) : r_b;
        w_sh    = i_ce ? 32'd0 : (32'(r_idx) * 32'(CW));
        w_ac    = CW'(w_a_pad >> w_sh);
        w_bc    = CW'(w_b_pad >> w_sh);
        w_s     = {1'b0, w_ac} + {1'b0, w_bc}  + {{CW{1'b0}}, (i_ce ? 1'b0 : r_cs)};
        w_d     = {1'b0, w_ac} + {1'b0, ~w_bc} + {{CW{1'b0}}, (i_ce ? 1'b1 : r_cd)};
        w_mask  = PW'({CW{1'b1}}) << w_sh;
        w_step  = i_ce || (r_idx != IW'(LATENCY));
    end

    // Chunk result, carry and chunk-index registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_b   <= '0;
            r_sum <= '0;
            r_sub <= '0;
            r_cs  <= 1'b0;
            r_cd  <= 1'b0;
            r_idx <= IW'(LATENCY);
        end else if (w_step) begin
            if (i_ce) begin
                r_b <= PW'(i_i);
            end
            r_idx <= i_ce ? IW'(1) : (r_idx + IW'(1));
            r_sum <= (r_sum & ~w_mask) | (PW'(w_s[CW-1:0]) << w_sh);
            r_sub <= (r_sub & ~w_mask) | (PW'(w_d[CW-1:0]) << w_sh);
            r_cs  <= w_s[CW];
            r_cd  <= w_d[CW];
        end
    end

    assign o_sum = r_sum[WIDTH-1:0];
    assign o_sub = r_sub[WIDTH-1:0];
endmodule

module math_pipelined_arbiter #(
    parameter int  WIDTH   = 16,
    parameter int  LATENCY = 4,
    parameter int  NUM_REQ = 4,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_op,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [IDW-1:0]           resp_id,
    output logic                     busy
);
    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_rr;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic [IDW-1:0]   r_id;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_data;
    logic [IDW-1:0]   r_resp_id;

    logic             w_any;
    logic [IDW-1:0]   w_pick;
    logic [IDW-1:0]   w_cand;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_op;
    logic             w_ce;
    logic [WIDTH-1:0] w_unit_i;
    logic [WIDTH-1:0] w_unit_d;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_sub;

    math_pipelined #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_unit (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ce    (w_ce),
        .i_i     (w_unit_i),
        .i_d     (w_unit_d),
        .o_sum   (w_sum),
        .o_sub   (w_sub)
    );

    // Round-robin pick: scan downward so the lowest offset from the pointer wins.
    always_comb begin
        w_any    = 1'b0;
        w_pick   = '0;
        w_cand   = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            w_cand = IDW'((int'(r_rr) + j) % NUM_REQ);
            if (req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end else begin
                w_any  = w_any;
            end
        end
        for (int n = 0; n < NUM_REQ; n++) begin
            if (w_pick == IDW'(n)) begin
                w_sel_a  = req_a[n*WIDTH +: WIDTH];
                w_sel_b  = req_b[n*WIDTH +: WIDTH];
                w_sel_op = req_op[n];
            end else begin
                w_sel_op = w_sel_op;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_any ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (r_cnt == CNTW'(0)) ? S_RESP : S_WAIT;
            S_RESP:  w_next = resp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // State outputs: grant, unit strobe and unit operands (zero outside ISSUE/WAIT).
    always_comb begin
        req_ready = '0;
        w_ce      = 1'b0;
        w_unit_i  = '0;
        w_unit_d  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready[w_pick] = 1'b1;
                end else begin
                    req_ready = '0;
                end
            end
            S_ISSUE: begin
                w_ce     = 1'b1;
                w_unit_i = r_b;
                w_unit_d = r_a;
            end
            S_WAIT:  w_unit_d = r_a;
            S_RESP:  w_unit_d = '0;
            default: w_unit_d = '0;
        endcase
    end

    // Request latch, rr pointer, ripple counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr         <= '0;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 1'b0;
            r_id         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        r_op <= w_sel_op;
                        r_id <= w_pick;
                        r_rr <= (w_pick == IDW'(NUM_REQ - 1)) ? '0 : (w_pick + IDW'(1));
                    end
                end
                S_ISSUE: r_cnt <= CNTW'(LATENCY - 1);
                S_WAIT: begin
                    if (r_cnt == CNTW'(0)) begin
                        r_resp_data  <= r_op ? w_sub : w_sum;
                        r_resp_id    <= r_id;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_resp_valid <= 1'b0;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_math_pipelined_arbiter.sv
// Directed bench for math_pipelined_arbiter: a 16-bit/4-deep/4-requester instance and a
// 13-bit/3-deep single-requester instance, each checked against hand-computed results.
module tb_math_pipelined_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready, req_op;
    logic [63:0] req_a, req_b;
    logic        resp_valid, resp_ready, busy;
    logic [15:0] resp_data;
    logic [1:0]  resp_id;

    logic [0:0]  n_valid, n_ready, n_op;
    logic [12:0] n_a, n_b, n_data;
    logic        n_rvalid, n_rready, n_busy;
    logic [0:0]  n_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    math_pipelined_arbiter #(.WIDTH(16), .LATENCY(4), .NUM_REQ(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
    );

    math_pipelined_arbiter #(.WIDTH(13), .LATENCY(3), .NUM_REQ(1)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .req_valid(n_valid), .req_ready(n_ready),
        .req_a(n_a), .req_b(n_b), .req_op(n_op), .resp_valid(n_rvalid),
        .resp_ready(n_rready), .resp_data(n_data), .resp_id(n_id), .busy(n_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0; n_valid = '0; n_rready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One request on requester n; returns result, id and edges from accept to resp_valid.
    task automatic run_op(input int n, input logic [15:0] a, input logic [15:0] b, input logic op,
                          output logic [15:0] data, output logic [1:0] id, output int lat);
        bit got;
        data = '0; id = '0; lat = -1; got = 1'b0;
        @(negedge clk);
        req_a[n*16 +: 16] = a; req_b[n*16 +: 16] = b; req_op[n] = op; req_valid[n] = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            #1;
            if (req_ready[n]) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            req_valid[n] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[n] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1; lat = t; data = resp_data; id = resp_id;
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run_op_n(input logic [12:0] a, input logic [12:0] b, input logic op,
                            output logic [12:0] data, output logic [0:0] id, output int lat);
        bit got;
        data = '0; id = '0; lat = -1; got = 1'b0;
        @(negedge clk);
        n_a = a; n_b = b; n_op = op; n_valid = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            #1;
            if (n_ready[0]) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            n_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 n_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (n_rvalid) begin
                got = 1'b1; lat = t; data = n_data; id = n_id;
            end
        end
        n_rready = 1'b1;
        @(posedge clk);
        #1 n_rready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({resp_valid, resp_data, resp_id, busy, req_ready} !== 24'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h id=%h busy=%b rdy=%b exp all zero",
                     resp_valid, resp_data, resp_id, busy, req_ready);
        end
        checks++;
        if ({n_rvalid, n_data, n_id, n_busy} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state_narrow got v=%b d=%h id=%h busy=%b exp all zero",
                     n_rvalid, n_data, n_id, n_busy);
        end
    endtask

    task automatic test_single_add();
        logic [15:0] d; logic [1:0] id; int lat;
        run_op(0, 16'h1234, 16'h0FFF, 1'b0, d, id, lat);
        checks++;
        if (d !== 16'h2233 || id !== 2'd0) begin
            errors++;
            $display("FAIL single_add got d=%h id=%0d exp d=2233 id=0", d, id);
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL single_add_latency got %0d exp 5", lat);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_add_idle got v=%b busy=%b exp 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_wrap();
        int          rq [5] = '{1, 2, 3, 0, 1};
        logic [15:0] ta [5] = '{16'hFFFF, 16'h0000, 16'h0FFF, 16'h8000, 16'h7FFF};
        logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
        logic        to [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] te [5] = '{16'h0000, 16'hFFFF, 16'h1000, 16'h7FFF, 16'h7FFE};
        logic [15:0] d; logic [1:0] id; int lat;
        for (int k = 0; k < 5; k++) begin
            run_op(rq[k], ta[k], tb[k], to[k], d, id, lat);
            checks++;
            if (d !== te[k] || id !== 2'(rq[k]) || lat !== 5) begin
                errors++;
                $display("FAIL wrap_%0d got d=%h id=%0d lat=%0d exp d=%h id=%0d lat=5",
                         k, d, id, lat, te[k], rq[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_d [4] = '{16'h1001, 16'h1FFF, 16'h3005, 16'h3FFF};
        int prev, exp_g;
        bit seen;
        do_reset();
        req_a = {16'h4003, 16'h3002, 16'h2001, 16'h1000};
        req_b = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        req_op = 4'b1010;
        resp_ready = 1'b1;
        req_valid = 4'hF;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            exp_g = g % 4;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                #1;
                if (|req_ready) seen = 1'b1;
                else @(negedge clk);
            end
            checks++;
            if (req_ready !== (4'b0001 << exp_g)) begin
                errors++;
                $display("FAIL rr_grant_%0d got %b exp %b", g, req_ready, 4'b0001 << exp_g);
            end
            if (g > 0) begin
                checks++;
                if (cyc - prev !== 7) begin
                    errors++;
                    $display("FAIL rr_throughput_%0d got %0d cycles exp 7", g, cyc - prev);
                end
            end
            prev = cyc;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (resp_valid) seen = 1'b1;
            end
            checks++;
            if (!seen || resp_data !== exp_d[exp_g] || resp_id !== 2'(exp_g)) begin
                errors++;
                $display("FAIL rr_resp_%0d got v=%b d=%h id=%0d exp d=%h id=%0d",
                         g, seen, resp_data, resp_id, exp_d[exp_g], exp_g);
            end
        end
        req_valid = '0;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        bit seen;
        @(negedge clk);
        req_a[16 +: 16] = 16'h00AA; req_b[16 +: 16] = 16'h0055; req_op[1] = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_grant got %b exp 0010", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        req_valid = 4'hF;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 16'h00FF || resp_id !== 2'd1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d got v=%b d=%h id=%0d busy=%b exp 1 00ff 1 1",
                         t, resp_valid, resp_data, resp_id, busy);
            end
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready_%0d got %b exp 0000", t, req_ready);
            end
        end
        req_valid = '0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got v=%b busy=%b exp 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d; logic [1:0] id; int lat, stray;
        @(negedge clk);
        req_a[32 +: 16] = 16'h1111; req_b[32 +: 16] = 16'h2222; req_op[2] = 1'b0;
        req_valid = 4'b0100;
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_state got busy=%b v=%b d=%h exp 0 0 0000", busy, resp_valid, resp_data);
        end
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_rr got %b exp 0001", req_ready);
        end
        req_valid = '0;
        stray = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL reset_mid_stray got %0d responses exp 0", stray);
        end
        run_op(0, 16'h4321, 16'h0321, 1'b1, d, id, lat);
        checks++;
        if (d !== 16'h4000 || id !== 2'd0 || lat !== 5) begin
            errors++;
            $display("FAIL reset_mid_op got d=%h id=%0d lat=%0d exp 4000 0 5", d, id, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, e, d; logic op; logic [1:0] id; int n, lat;
        for (int k = 0; k < 200; k++) begin
            n = int'($urandom_range(0, 3));
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
            e = op ? (a - b) : (a + b);
            run_op(n, a, b, op, d, id, lat);
            checks++;
            if (d !== e || id !== 2'(n) || lat !== 5) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h op=%b got d=%h id=%0d lat=%0d exp d=%h id=%0d lat=5",
                         k, a, b, op, d, id, lat, e, n);
            end
        end
    endtask

    task automatic test_narrow();
        logic [12:0] a, b, e, d; logic op; logic [0:0] id; int lat;
        run_op_n(13'h1FFF, 13'h0001, 1'b0, d, id, lat);
        checks++;
        if (d !== 13'h0000 || id !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL narrow_wrap_add got d=%h id=%0d lat=%0d exp 0000 0 4", d, id, lat);
        end
        run_op_n(13'h0000, 13'h0001, 1'b1, d, id, lat);
        checks++;
        if (d !== 13'h1FFF || id !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL narrow_wrap_sub got d=%h id=%0d lat=%0d exp 1fff 0 4", d, id, lat);
        end
        for (int k = 0; k < 100; k++) begin
            a = 13'($urandom); b = 13'($urandom); op = 1'($urandom);
            e = op ? (a - b) : (a + b);
            run_op_n(a, b, op, d, id, lat);
            checks++;
            if (d !== e || id !== 1'b0 || lat !== 4) begin
                errors++;
                $display("FAIL narrow_%0d a=%h b=%h op=%b got d=%h id=%0d lat=%0d exp d=%h id=0 lat=4",
                         k, a, b, op, d, id, lat, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
        n_valid = '0; n_a = '0; n_b = '0; n_op = '0; n_rready = 1'b0;
        test_reset();
        test_single_add();
        test_wrap();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_random();
        test_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
